// File: rtl/data_memory_sized.sv
// Sized load/store data memory with a valid/ready request port and a one-cycle
// response pulse; little-endian byte lanes, ARM7-style rotated word loads.
module data_memory_sized #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int unsigned WAIT_STATES = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_abort
);

   localparam int unsigned IDX_W     = $clog2(DEPTH_WORDS);
   localparam logic [3:0]  WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_RSVD = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP
   } state_e;

   state_e      state_q;
   logic [3:0]  cnt_q;
   logic        req_ready_q;
   logic        rsp_valid_q;

   logic        load_q;
   logic [1:0]  size_q;
   logic        signed_q;
   logic [1:0]  shift_q;
   logic        abort_q;

   logic [31:0] hold_rdata_q;
   logic        hold_abort_q;

   logic             accept;
   logic [31:0]      offset;
   logic             out_of_range;
   logic             misaligned;
   logic             req_abort;
   logic             rd_en;
   logic [IDX_W-1:0] word_idx;
   logic [3:0]       lane_we;
   logic [31:0]      lane_wdata;
   logic [31:0]      ram_rdata;
   logic [31:0]      rot_word;
   logic [31:0]      rsp_rdata_d;

   // BASE_ADDR is word-aligned, so offset[1:0] equals the byte lane of req_addr.
   assign accept       = rst_n & req_valid & req_ready_q;
   assign offset       = req_addr - BASE_ADDR;
   assign out_of_range = (req_addr < BASE_ADDR) ||
                         ({2'b00, offset[31:2]} >= 32'(DEPTH_WORDS));
   assign misaligned   = (req_size == SZ_HALF) && offset[0];
   assign req_abort    = (req_size == SZ_RSVD) || out_of_range || misaligned;
   assign word_idx     = offset[IDX_W+1:2];
   assign rd_en        = accept & ~req_write & ~req_abort;

   always_comb begin
      lane_we    = 4'b0000;
      lane_wdata = req_wdata;
      case (req_size)
         SZ_BYTE: begin
            lane_we    = 4'b0001 << offset[1:0];
            lane_wdata = {4{req_wdata[7:0]}};
         end
         SZ_HALF: begin
            lane_we    = offset[1] ? 4'b1100 : 4'b0011;
            lane_wdata = {2{req_wdata[15:0]}};
         end
         SZ_WORD: lane_we = 4'b1111;
         default: lane_we = 4'b0000;
      endcase
      if (!(accept && req_write) || req_abort) begin
         lane_we = 4'b0000;
      end
   end

   // One byte-wide RAM per lane so each lane gets its own write enable.
   for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem_q [DEPTH_WORDS];
      logic [7:0] rd_q;

      always_ff @(posedge clk) begin
         if (lane_we[gi]) begin
            mem_q[word_idx] <= lane_wdata[8*gi +: 8];
         end
         if (rd_en) begin
            rd_q <= mem_q[word_idx];
         end
      end

      assign ram_rdata[8*gi +: 8] = rd_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         load_q   <= 1'b0;
         size_q   <= SZ_BYTE;
         signed_q <= 1'b0;
         shift_q  <= 2'b00;
         abort_q  <= 1'b0;
      end else if (accept) begin
         load_q   <= ~req_write;
         size_q   <= req_size;
         signed_q <= req_signed;
         shift_q  <= offset[1:0];
         abort_q  <= req_abort;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= 4'd0;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  req_ready_q <= 1'b0;
                  if (WAIT_STATES == 0) begin
                     state_q     <= S_RESP;
                     rsp_valid_q <= 1'b1;
                  end else begin
                     state_q <= S_WAIT;
                     cnt_q   <= WAIT_LOAD;
                  end
               end
            end
            S_WAIT: begin
               if (cnt_q == 4'd0) begin
                  state_q     <= S_RESP;
                  rsp_valid_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            S_RESP: begin
               state_q     <= S_IDLE;
               rsp_valid_q <= 1'b0;
               req_ready_q <= 1'b1;
            end
            default: begin
               state_q     <= S_IDLE;
               cnt_q       <= 4'd0;
               rsp_valid_q <= 1'b0;
               req_ready_q <= 1'b1;
            end
         endcase
      end
   end

   // Byte and halfword results are the low bits of the rotated word.
   assign rot_word = 32'({ram_rdata, ram_rdata} >> {shift_q, 3'b000});

   always_comb begin
      rsp_rdata_d = 32'd0;
      if (load_q && !abort_q) begin
         case (size_q)
            SZ_BYTE: rsp_rdata_d = signed_q ? {{24{rot_word[7]}}, rot_word[7:0]}
                                            : {24'd0, rot_word[7:0]};
            SZ_HALF: rsp_rdata_d = signed_q ? {{16{rot_word[15]}}, rot_word[15:0]}
                                            : {16'd0, rot_word[15:0]};
            default: rsp_rdata_d = rot_word;
         endcase
      end
   end

   // The RAM output register is reused by the next load, so the response is latched for holding.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hold_rdata_q <= 32'd0;
         hold_abort_q <= 1'b0;
      end else if (rsp_valid_q) begin
         hold_rdata_q <= rsp_rdata_d;
         hold_abort_q <= abort_q;
      end
   end

   assign req_ready = req_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_valid_q ? rsp_rdata_d : hold_rdata_q;
   assign rsp_abort = rsp_valid_q ? abort_q : hold_abort_q;

endmodule
